fifo_burst_reader: RTL and testbench

- Read-side controller for the team's synchronous byte FIFO.
- Watches the FIFO occupancy and drains it in bursts of up to BURST_LEN entries.
- Presents each entry on a valid/ready output stream to the downstream consumer, so the FIFO's read_data/empty/data_output side no longer needs manual driving.
- A timeout flushes partial bursts, so data never sits in the FIFO indefinitely.

---
 rtl/fifo_burst_reader.sv | 170 +++++++++++++++++
 tb/tb_fifo_burst_reader.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_burst_reader.sv
// fifo_burst_reader
// Read-side controller for a synchronous byte FIFO. It watches the FIFO occupancy and drains
// it in bursts of up to BURST_LEN entries. Each entry is presented on a valid/ready stream.
// If the FIFO holds fewer than BURST_LEN entries for TIMEOUT idle cycles, a partial burst is
// forced, so data is never stranded.
//
// Ports
//   clk         rising-edge clock
//   rst         asynchronous, active-high reset (release synchronously)
//   fifo_empty  FIFO empty flag
//   fifo_count  FIFO occupancy
//   fifo_data   FIFO read data, valid RD_LATENCY cycles after fifo_rd
//   fifo_rd     FIFO read strobe, one cycle per popped entry
//   m_valid     output stream valid
//   m_ready     output stream ready from the consumer
//   m_data      output stream data, stable while m_valid is high
//   busy        high whenever the controller is not idle
//   burst_done  one-cycle pulse after each burst ends
//   byte_count  number of completed output handshakes, wraps at 2^16
module fifo_burst_reader #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned DEPTH      = 16,
   parameter int unsigned BURST_LEN  = 4,
   parameter int unsigned TIMEOUT    = 8,
   parameter int unsigned RD_LATENCY = 1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   fifo_empty,
   input  logic [$clog2(DEPTH):0] fifo_count,
   input  logic [DATA_WIDTH-1:0]  fifo_data,
   output logic                   fifo_rd,
   output logic                   m_valid,
   input  logic                   m_ready,
   output logic [DATA_WIDTH-1:0]  m_data,
   output logic                   busy,
   output logic                   burst_done,
   output logic [15:0]            byte_count
);

   localparam int unsigned CntW = $clog2(DEPTH) + 1;
   localparam int unsigned TmrW = $clog2(TIMEOUT + 1);
   localparam int unsigned BstW = $clog2(BURST_LEN + 1);
   localparam int unsigned LatW = $clog2(RD_LATENCY + 1);

   localparam logic [CntW-1:0] BurstLenCnt = CntW'(BURST_LEN);
   localparam logic [BstW-1:0] BurstLenBst = BstW'(BURST_LEN);
   localparam logic [TmrW-1:0] TimeoutTmr  = TmrW'(TIMEOUT);
   localparam logic [LatW-1:0] LatLast     = LatW'(RD_LATENCY - 1);

   typedef enum logic [1:0] {
      StIdle,
      StPop,
      StWait,
      StHold
   } state_e;

   state_e                state_q, state_d;
   logic [TmrW-1:0]       timer_q, timer_d;
   logic [TmrW-1:0]       timer_inc;
   logic [BstW-1:0]       burst_cnt_q, burst_cnt_d;
   logic [LatW-1:0]       lat_q, lat_d;
   logic [DATA_WIDTH-1:0] m_data_q, m_data_d;
   logic [15:0]           byte_count_q, byte_count_d;
   logic                  burst_done_q, burst_done_d;

   // ---------------------------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------------------------
   always_comb begin
      state_d      = state_q;
      timer_d      = timer_q;
      burst_cnt_d  = burst_cnt_q;
      lat_d        = lat_q;
      m_data_d     = m_data_q;
      byte_count_d = byte_count_q;
      burst_done_d = 1'b0;
      fifo_rd      = 1'b0;
      // Never exceeds TIMEOUT: IDLE is left on the cycle this value reaches TIMEOUT.
      timer_inc    = timer_q + 1'b1;

      case (state_q)
         StIdle: begin
            if (fifo_empty) begin
               timer_d = '0;
            end else if ((fifo_count >= BurstLenCnt) || (timer_inc >= TimeoutTmr)) begin
               // A full burst and an expiring timer in the same cycle start one burst only.
               state_d     = StPop;
               timer_d     = '0;
               burst_cnt_d = '0;
            end else begin
               timer_d = timer_inc;
            end
         end

         StPop: begin
            if (fifo_empty) begin
               // Nothing left to read: close the burst without touching the FIFO.
               state_d      = StIdle;
               burst_done_d = 1'b1;
            end else begin
               fifo_rd = 1'b1;
               lat_d   = '0;
               state_d = StWait;
            end
         end

         StWait: begin
            // fifo_data becomes valid RD_LATENCY cycles after the read strobe.
            if (lat_q == LatLast) begin
               m_data_d = fifo_data;
               state_d  = StHold;
            end else begin
               lat_d = lat_q + 1'b1;
            end
         end

         StHold: begin
            if (m_ready) begin
               byte_count_d = byte_count_q + 16'd1;
               burst_cnt_d  = burst_cnt_q + 1'b1;
               if ((burst_cnt_d == BurstLenBst) || fifo_empty) begin
                  state_d      = StIdle;
                  burst_done_d = 1'b1;
               end else begin
                  state_d = StPop;
               end
            end
         end

         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // ---------------------------------------------------------------------------------------
   // State registers
   // ---------------------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= StIdle;
         timer_q      <= '0;
         burst_cnt_q  <= '0;
         lat_q        <= '0;
         m_data_q     <= '0;
         byte_count_q <= '0;
         burst_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         timer_q      <= timer_d;
         burst_cnt_q  <= burst_cnt_d;
         lat_q        <= lat_d;
         m_data_q     <= m_data_d;
         byte_count_q <= byte_count_d;
         burst_done_q <= burst_done_d;
      end
   end

   // ---------------------------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------------------------
   // Decoded from the state register only, so a reset drops m_valid and busy immediately.
   assign m_valid    = (state_q == StHold);
   assign busy       = (state_q != StIdle);
   assign m_data     = m_data_q;
   assign byte_count = byte_count_q;
   assign burst_done = burst_done_q;

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Self-checking bench for fifo_burst_reader. A small behavioural FIFO with one cycle of read
// latency feeds the DUT. Written bytes are queued as expected output and compared on each
// handshake.
module tb_fifo_burst_reader;

   logic       clk;
   logic       rst;
   logic       fifo_empty;
   logic [4:0] fifo_count;
   logic [7:0] fifo_data;
   logic       fifo_rd;
   logic       m_valid;
   logic       m_ready;
   logic [7:0] m_data;
   logic       busy;
   logic       burst_done;
   logic [15:0] byte_count;

   fifo_burst_reader #(
      .DATA_WIDTH(8),
      .DEPTH     (16),
      .BURST_LEN (4),
      .TIMEOUT   (8),
      .RD_LATENCY(1)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .fifo_empty(fifo_empty),
      .fifo_count(fifo_count),
      .fifo_data (fifo_data),
      .fifo_rd   (fifo_rd),
      .m_valid   (m_valid),
      .m_ready   (m_ready),
      .m_data    (m_data),
      .busy      (busy),
      .burst_done(burst_done),
      .byte_count(byte_count)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // ---------------------------------------------------------------- FIFO model
   logic        wr_en;
   logic [7:0]  wr_data;
   logic [7:0]  mem [64];
   logic [31:0] wp = 32'd0;
   logic [31:0] rp = 32'd0;

   initial fifo_data = 8'h00;

   always @(posedge clk) begin
      if (wr_en) begin
         mem[wp[5:0]] <= wr_data;
         wp           <= wp + 32'd1;
      end
      if (fifo_rd) begin
         fifo_data <= mem[rp[5:0]];
         rp        <= rp + 32'd1;
      end
   end

   assign fifo_count = 5'(wp - rp);
   assign fifo_empty = (wp == rp);

   // ---------------------------------------------------------------- bookkeeping
   int n_cmp = 0;
   int n_err = 0;
   int cyc   = 0;
   int rd_cnt;
   int bd_cnt;
   int hs_cyc;
   logic [7:0] exp_q[$];
   int rd_cyc_q[$];
   int bd_cyc_q[$];
   int bd_rd_q[$];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Monitor samples mid-cycle; inputs change 1 time unit after the rising edge.
   always @(negedge clk) begin
      if (!rst) begin
         if (fifo_rd) begin
            rd_cnt++;
            rd_cyc_q.push_back(cyc);
            check_eq("rd_while_empty", {31'd0, fifo_empty}, 32'd0);
            check_eq("rd_while_valid", {31'd0, m_valid}, 32'd0);
         end
         if (m_valid && m_ready) begin
            hs_cyc = cyc;
            if (exp_q.size() == 0) check_eq("unexpected_data", {24'd0, m_data}, 32'hFFFF_FFFF);
            else check_eq("data_order", {24'd0, m_data}, {24'd0, exp_q.pop_front()});
         end
         if (burst_done) begin
            bd_cnt++;
            bd_cyc_q.push_back(cyc);
            bd_rd_q.push_back(rd_cnt);
         end
      end
   end

   // ---------------------------------------------------------------- stimulus helpers
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [7:0] b);
      wr_en   = 1'b1;
      wr_data = b;
      exp_q.push_back(b);
      step();
      wr_en   = 1'b0;
   endtask

   task automatic do_reset();
      rst    = 1'b1;
      wr_en  = 1'b0;
      rd_cnt = 0;
      bd_cnt = 0;
      hs_cyc = 0;
      exp_q.delete();
      rd_cyc_q.delete();
      bd_cyc_q.delete();
      bd_rd_q.delete();
      repeat (3) step();
      rst = 1'b0;
      step();
   endtask

   task automatic wait_bd(input int n, input int limit, input string tag);
      int t = 0;
      while (bd_cnt < n && t < limit) begin
         step();
         t++;
      end
      check_eq(tag, bd_cnt, n);
   endtask

   task automatic wait_valid(input int limit, input string tag);
      int t = 0;
      while (!m_valid && t < limit) begin
         step();
         t++;
      end
      check_eq(tag, {31'd0, m_valid}, 32'd1);
   endtask

   // ---------------------------------------------------------------- tests
   initial begin
      int c0;
      rst     = 1'b1;
      wr_en   = 1'b0;
      wr_data = 8'h00;
      m_ready = 1'b1;
      rd_cnt  = 0;
      bd_cnt  = 0;
      hs_cyc  = 0;

      // Reset held three cycles.
      repeat (3) step();
      check_eq("rst_fifo_rd", {31'd0, fifo_rd}, 32'd0);
      check_eq("rst_m_valid", {31'd0, m_valid}, 32'd0);
      check_eq("rst_busy", {31'd0, busy}, 32'd0);
      check_eq("rst_burst_done", {31'd0, burst_done}, 32'd0);
      check_eq("rst_byte_count", {16'd0, byte_count}, 32'd0);
      check_eq("rst_m_data", {24'd0, m_data}, 32'd0);
      rst = 1'b0;
      step();
      check_eq("post_rst_busy", {31'd0, busy}, 32'd0);

      // Full burst of four with the consumer always ready.
      do_reset();
      wr(8'h11); wr(8'h22); wr(8'h33); wr(8'h44);
      wait_bd(1, 60, "t2_burst_done");
      repeat (4) step();
      check_eq("t2_rd_count", rd_cyc_q.size(), 4);
      if (rd_cyc_q.size() == 4)
         for (int i = 1; i < 4; i++) check_eq("t2_rd_gap", rd_cyc_q[i] - rd_cyc_q[i-1], 3);
      check_eq("t2_bd_count", bd_cnt, 1);
      check_eq("t2_byte_count", {16'd0, byte_count}, 32'd4);
      check_eq("t2_fifo_empty", {31'd0, fifo_empty}, 32'd1);
      check_eq("t2_all_delivered", exp_q.size(), 0);

      // Partial burst forced by the timeout.
      do_reset();
      wr(8'hA5);
      c0 = cyc;
      wr(8'h5A);
      wait_bd(1, 60, "t3_burst_done");
      check_eq("t3_rd_count", rd_cyc_q.size(), 2);
      if (rd_cyc_q.size() > 0) check_eq("t3_timeout_delay", rd_cyc_q[0] - c0, 8);
      if (bd_cyc_q.size() > 0) check_eq("t3_bd_after_hs", bd_cyc_q[0] - hs_cyc, 1);
      check_eq("t3_byte_count", {16'd0, byte_count}, 32'd2);
      check_eq("t3_all_delivered", exp_q.size(), 0);

      // Backpressure while holding the first entry.
      do_reset();
      m_ready = 1'b0;
      wr(8'hB1); wr(8'hB2); wr(8'hB3); wr(8'hB4);
      wait_valid(40, "t4_valid_seen");
      repeat (5) begin
         step();
         check_eq("t4_stall_valid", {31'd0, m_valid}, 32'd1);
         if (exp_q.size() > 0) check_eq("t4_stall_data", {24'd0, m_data}, {24'd0, exp_q[0]});
      end
      check_eq("t4_no_rd_in_stall", rd_cnt, 1);
      m_ready = 1'b1;
      step();
      check_eq("t4_resume", {16'd0, byte_count}, 32'd1);
      wait_bd(1, 60, "t4_burst_done");
      check_eq("t4_byte_count", {16'd0, byte_count}, 32'd4);
      check_eq("t4_all_delivered", exp_q.size(), 0);

      // Ten entries: two full bursts and a timed-out remainder.
      do_reset();
      for (int i = 1; i <= 10; i++) wr(8'(i));
      wait_bd(3, 200, "t5_burst_done");
      check_eq("t5_rd_count", rd_cyc_q.size(), 10);
      if (bd_rd_q.size() == 3) begin
         check_eq("t5_burst1", bd_rd_q[0], 4);
         check_eq("t5_burst2", bd_rd_q[1], 8);
         check_eq("t5_burst3", bd_rd_q[2], 10);
      end
      if (rd_cyc_q.size() == 10 && bd_cyc_q.size() >= 2)
         check_eq("t5_timeout_delay", rd_cyc_q[8] - bd_cyc_q[1], 8);
      check_eq("t5_byte_count", {16'd0, byte_count}, 32'd10);
      check_eq("t5_all_delivered", exp_q.size(), 0);

      // Reset while an entry is held; the held entry is discarded.
      do_reset();
      m_ready = 1'b0;
      for (int i = 0; i < 6; i++) wr(8'hC0 + 8'(i));
      wait_valid(40, "t6_valid_seen");
      #2;
      rst = 1'b1;
      #1;
      check_eq("t6_async_m_valid", {31'd0, m_valid}, 32'd0);
      check_eq("t6_async_busy", {31'd0, busy}, 32'd0);
      check_eq("t6_async_byte_count", {16'd0, byte_count}, 32'd0);
      check_eq("t6_async_fifo_rd", {31'd0, fifo_rd}, 32'd0);
      if (exp_q.size() > 0) void'(exp_q.pop_front());
      step();
      step();
      rst     = 1'b0;
      m_ready = 1'b1;
      wait_bd(2, 200, "t6_burst_done");
      check_eq("t6_byte_count", {16'd0, byte_count}, 32'd5);
      check_eq("t6_rd_total", rd_cnt, 6);
      check_eq("t6_all_delivered", exp_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
